uart_tx_arbiter: RTL and testbench

Shares one UART transmit serializer (8N1, fixed baud) between `NUM_REQ` byte producers using round-robin arbitration. Each requester offers a byte with a valid/ready handshake. The arbiter grants one requester, captures its byte, and drives the frame onto the single `tx` line. It sits between on-chip message sources (status reporters, debug streams) and the board UART pin, replacing the hard-wired single-source transmitter.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_serializer.sv | 59 +++++
 rtl/uart_tx_arbiter.sv | 98 +++++++++
 tb/tb_uart_tx_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path.
package uart_pkg;

    localparam int FRAME_BITS        = 10;
    localparam int DEFAULT_CLK_VALUE = 100_000_000;
    localparam int DEFAULT_BAUD      = 9600;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

    function automatic int calc_bit_cycles(input int clk_value, input int baud);
        return clk_value / baud;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit, each BIT_CYCLES clocks.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int IW = $clog2(FRAME_BITS);

    logic [CW-1:0] bit_cnt_reg;
    logic [IW-1:0] bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          active_reg;
    logic          bit_end;

    assign bit_end = (bit_cnt_reg == CW'(BIT_CYCLES - 1));
    // Asserted during the last cycle of the stop bit so the owner can react on the same edge.
    assign done    = active_reg && bit_end && (bit_idx_reg == IW'(FRAME_BITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx          <= 1'b1;
            active_reg  <= 1'b0;
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else if (load && !active_reg) begin
            shift_reg   <= data;
            tx          <= 1'b0;
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            active_reg  <= 1'b1;
        end else if (active_reg) begin
            if (bit_end) begin
                bit_cnt_reg <= '0;
                if (bit_idx_reg == IW'(FRAME_BITS - 1)) begin
                    active_reg <= 1'b0;
                    tx         <= 1'b1;
                end else begin
                    // Ones shift in behind the data, so the stop bit falls out naturally.
                    bit_idx_reg <= bit_idx_reg + 1'b1;
                    tx          <= shift_reg[0];
                    shift_reg   <= {1'b1, shift_reg[7:1]};
                end
            end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART serializer among NUM_REQ byte producers.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CLK_VALUE = DEFAULT_CLK_VALUE,
    parameter int BAUD      = DEFAULT_BAUD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       frame_done
);

    localparam int BIT_CYCLES = calc_bit_cycles(CLK_VALUE, BAUD);
    localparam int PW         = $clog2(NUM_REQ);

    arb_state_t    state_reg;
    logic [PW-1:0] rr_ptr_reg;
    logic [PW-1:0] pick;
    logic          pick_found;
    logic          load;
    logic          ser_done;
    logic [7:0]    req_byte [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign req_byte[gi] = req_data[8*gi +: 8];
    end

    // Walk offsets from high to low so the closest set bit at or after rr_ptr wins.
    always_comb begin
        logic [PW:0] sum;
        pick       = '0;
        pick_found = 1'b0;
        sum        = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_reg} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ))
                sum = sum - (PW+1)'(NUM_REQ);
            if (req_valid[sum[PW-1:0]]) begin
                pick       = sum[PW-1:0];
                pick_found = 1'b1;
            end
        end
    end

    assign load = (state_reg == IDLE) && pick_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            grant_id   <= '0;
            req_ready  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            req_ready  <= '0;
            frame_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        state_reg  <= SEND;
                        grant_id   <= pick;
                        req_ready  <= NUM_REQ'(1) << pick;
                        rr_ptr_reg <= (pick == PW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                        busy       <= 1'b1;
                    end
                end
                SEND: begin
                    if (ser_done) begin
                        state_reg  <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    uart_tx_serializer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_ser (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .data (req_byte[pick]),
        .tx   (tx),
        .done (ser_done)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a round-robin/frame model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int BC = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          tx;
    logic          busy;
    logic [1:0]    grant_id;
    logic          frame_done;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [N-1:0] pend_valid = '0;
    logic [7:0]   pend_data [N];
    int           model_ptr = 0;

    uart_tx_arbiter #(
        .NUM_REQ   (N),
        .CLK_VALUE (16),
        .BAUD      (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend_valid[i];
            req_data[i*8 +: 8] = pend_data[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pend_valid = '0;
        drive();
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_grant_id", grant_id, 0);
        rst = 1'b0;
        model_ptr = 0;
    endtask

    task automatic idle_check(input int cycles, input string tag);
        bit ok = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== '0 || frame_done !== 1'b0) ok = 1'b0;
        end
        chk(tag, ok, 1);
    endtask

    // Expects the model's next grant, a full 10-bit frame and the frame_done pulse.
    task automatic expect_frame(input int glitch_at, input logic [N-1:0] glitch_mask);
        int         g;
        int         n;
        logic [7:0] b;
        logic [9:0] fb;
        bit         ok_tx;
        bit         ok_side;
        g = rr_pick(pend_valid, model_ptr);
        if (g < 0) return;
        b  = pend_data[g];
        fb = {1'b1, b, 1'b0};
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready === '0 && n < 400);
        chk("grant_latency", n, 1);
        if (req_ready === '0) return;
        chk("req_ready", req_ready, 32'(1) << g);
        chk("grant_id", grant_id, g);
        chk("busy_at_grant", busy, 1);
        pend_valid[g] = 1'b0;
        drive();
        model_ptr = (g + 1) % N;
        for (int k = 0; k < 10; k++) begin
            ok_tx   = 1'b1;
            ok_side = 1'b1;
            for (int c = 0; c < BC; c++) begin
                int i;
                i = k * BC + c;
                if (i != 0) @(negedge clk);
                if (tx !== fb[k]) ok_tx = 1'b0;
                if (busy !== 1'b1 || frame_done !== 1'b0 || (i != 0 && req_ready !== '0)) ok_side = 1'b0;
                if (i == glitch_at) req_valid = req_valid | glitch_mask;
                else if (i == glitch_at + 1) drive();
            end
            chk($sformatf("tx_bit%0d", k), ok_tx, 1);
            chk("frame_side", ok_side, 1);
        end
        @(negedge clk);
        chk("frame_done", frame_done, 1);
        chk("busy_after", busy, 0);
        chk("tx_after", tx, 1);
        chk("ready_after", req_ready, 0);
        $display("frame: requester %0d byte %02h grant_latency %0d", g, b, n);
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) pend_data[i] = '0;

        // Single request from requester 1.
        do_reset();
        pend_valid[1] = 1'b1; pend_data[1] = 8'h41; drive();
        expect_frame(-1, '0);
        idle_check(20, "idle_after_single");

        // All four valid at once: strict order 0,1,2,3 back to back.
        do_reset();
        for (int i = 0; i < N; i++) begin
            pend_valid[i] = 1'b1;
            pend_data[i]  = 8'h10 + 8'(i);
        end
        drive();
        repeat (4) expect_frame(-1, '0);
        idle_check(20, "idle_after_all4");

        // Requesters 0 and 2 continuously valid: alternate with a 17-cycle stop gap.
        do_reset();
        pend_valid[0] = 1'b1; pend_data[0] = 8'hA0;
        pend_valid[2] = 1'b1; pend_data[2] = 8'hC0;
        drive();
        for (int f = 0; f < 4; f++) begin
            int last;
            last = rr_pick(pend_valid, model_ptr);
            expect_frame(-1, '0);
            pend_valid[last] = 1'b1;
            pend_data[last]  = pend_data[last] + 8'h01;
            drive();
        end
        pend_valid = '0; drive();
        chk("cont_last_grant", grant_id, 2);

        // One-cycle valid from requester 3 during SEND is ignored.
        do_reset();
        pend_valid[0] = 1'b1; pend_data[0] = 8'h3C; drive();
        expect_frame(50, 4'b1000);
        idle_check(40, "idle_after_glitch");

        // Reset pulsed during data bit 4 aborts the frame.
        do_reset();
        pend_valid[2] = 1'b1; pend_data[2] = 8'h05; drive();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready === '0 && n < 20);
        chk("mid_rst_grant", req_ready, 4'b0100);
        pend_valid[2] = 1'b0; drive();
        repeat (88) @(negedge clk);
        chk("tx_databit4", tx, 0);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_grant_id", grant_id, 0);
        chk("async_rst_ready", req_ready, 0);
        chk("async_rst_frame_done", frame_done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        $display("reset: mid-frame abort at data bit 4");
        idle_check(200, "no_frame_done_after_rst");
        pend_valid[1] = 1'b1; pend_data[1] = 8'h5A;
        pend_valid[3] = 1'b1; pend_data[3] = 8'hE7;
        drive();
        expect_frame(-1, '0);
        expect_frame(-1, '0);
        pend_valid[0] = 1'b1; pend_data[0] = 8'h99; drive();
        expect_frame(-1, '0);

        // Valid rising in the frame_done cycle is granted at that edge.
        do_reset();
        pend_valid[1] = 1'b1; pend_data[1] = 8'h77; drive();
        expect_frame(-1, '0);
        pend_valid[2] = 1'b1; pend_data[2] = 8'h88; drive();
        expect_frame(-1, '0);

        // Randomized request patterns.
        do_reset();
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_valid[i] && $urandom_range(0, 2) == 0) begin
                    pend_valid[i] = 1'b1;
                    pend_data[i]  = 8'($urandom);
                end
            end
            if (pend_valid == '0) begin
                int r;
                idle_check($urandom_range(1, 5), "rand_idle");
                r = $urandom_range(0, N - 1);
                pend_valid[r] = 1'b1;
                pend_data[r]  = 8'($urandom);
            end
            drive();
            expect_frame(-1, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
